exu_br_event_ctr: RTL and testbench

//  Parametrised branch-resolution event counter bank in the EXU, next to the ALU control blocks.

---
 rtl/exu_br_event_ctr_pkg.sv | 36 +++
 rtl/exu_br_ctr_slice.sv | 71 +++++++
 rtl/exu_br_event_ctr.sv | 121 ++++++++++++
 tb/tb_exu_br_event_ctr.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_br_event_ctr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exu_br_event_ctr_pkg
//  Description : Shared types for the EXU branch-resolution event counters.
//                br_evt_e is the 3-bit event selector.
//                ctr_cfg_t packs {en, mode, evsel}, which is wr_data[4:0]
//                on a config write.
//  Revision    : 1.0  initial release
// ============================================================================
package exu_br_event_ctr_pkg;

  typedef enum logic [2:0] {
    EVT_NONE        = 3'd0,
    EVT_BR          = 3'd1,
    EVT_BR_TAKEN    = 3'd2,
    EVT_BR_NT       = 3'd3,
    EVT_COND_MISP   = 3'd4,
    EVT_TGT_MISP    = 3'd5,
    EVT_JAL         = 3'd6,
    EVT_FLUSH_UPPER = 3'd7
  } br_evt_e;

  localparam int NUM_EVT = 8;

  // mode: 0 = wrap, 1 = saturate
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef struct packed {
    logic    en;
    logic    mode;
    br_evt_e evsel;
  } ctr_cfg_t;

endpackage
`default_nettype wire

// File: rtl/exu_br_ctr_slice.sv
`default_nettype none
// ============================================================================
//  Module      : exu_br_ctr_slice
//  Description : One programmable event counter, with its config and a
//                sticky overflow flag.
//  Ports       : clk, rst_l        clock, asynchronous active-low reset
//                freeze            suppresses this cycle's increment
//                evt_vec           registered per-lane events, by selector
//                wr_cnt / wr_cfg   decoded write strobes for this counter
//                wr_data           write data (config uses [4:0])
//                cnt, cfg, ovf     current state
//  Revision    : 1.0  initial release
// ============================================================================
module exu_br_ctr_slice
  import exu_br_event_ctr_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CTR_W     = 32
) (
  input  logic                                clk,
  input  logic                                rst_l,
  input  logic                                freeze,
  input  logic [NUM_EVT-1:0][NUM_LANES-1:0]   evt_vec,
  input  logic                                wr_cnt,
  input  logic                                wr_cfg,
  input  logic [CTR_W-1:0]                    wr_data,
  output logic [CTR_W-1:0]                    cnt,
  output ctr_cfg_t                            cfg,
  output logic                                ovf
);

  localparam int SW = CTR_W + 1;

  logic [SW-1:0] w_inc;
  logic [SW-1:0] w_sum;
  logic          w_carry;

  // Population count over lanes of the selected event.
  always_comb begin
    w_inc = '0;
    if (cfg.en && !freeze) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        w_inc = w_inc + SW'(evt_vec[cfg.evsel][l]);
      end
    end
  end

  assign w_sum   = {1'b0, cnt} + w_inc;
  assign w_carry = w_sum[CTR_W];

  // A write to this counter takes the edge; any increment due on it is lost.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
      cfg <= '0;
      ovf <= 1'b0;
    end else if (wr_cfg) begin
      cfg <= ctr_cfg_t'(wr_data[4:0]);
      ovf <= 1'b0;
    end else if (wr_cnt) begin
      cnt <= wr_data;
    end else begin
      cnt <= (w_carry && (cfg.mode == MODE_SAT)) ? {CTR_W{1'b1}} : w_sum[CTR_W-1:0];
      if (w_carry) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exu_br_event_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : exu_br_event_ctr
//  Description : Branch-resolution event counter bank. It registers the
//                per-lane events (E1) and counts them in NUM_CTR programmable
//                counters (E2). It also provides a CSR/debug read/write port.
//  Ports       : clk, rst_l         clock, asynchronous active-low reset
//                freeze, flush      pipeline freeze / lower flush
//                ev_*               per-lane resolution events
//                wr_en/cfg/addr/data, rd_addr/cfg   register access
//                rd_data            combinational read of pre-edge state
//                ovf, ovf_any       sticky overflow flags, registered OR
//  Revision    : 1.0  initial release
// ============================================================================
module exu_br_event_ctr
  import exu_br_event_ctr_pkg::*;
#(
  parameter  int NUM_LANES = 2,
  parameter  int NUM_CTR   = 4,
  parameter  int CTR_W     = 32,
  localparam int AW        = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [NUM_LANES-1:0] ev_valid,
  input  logic [NUM_LANES-1:0] ev_is_branch,
  input  logic [NUM_LANES-1:0] ev_is_branch_t,
  input  logic [NUM_LANES-1:0] ev_misp,
  input  logic [NUM_LANES-1:0] ev_tgt_misp,
  input  logic [NUM_LANES-1:0] ev_jal,
  input  logic [NUM_LANES-1:0] ev_flush_upper,
  input  logic                 wr_en,
  input  logic                 wr_cfg,
  input  logic [AW-1:0]        wr_addr,
  input  logic [CTR_W-1:0]     wr_data,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_cfg,
  output logic [CTR_W-1:0]     rd_data,
  output logic [NUM_CTR-1:0]   ovf,
  output logic                 ovf_any
);

  logic [NUM_LANES-1:0]                w_qual;
  logic [NUM_EVT-1:0][NUM_LANES-1:0]   w_evt;
  logic [NUM_EVT-1:0][NUM_LANES-1:0]   r_evt;
  logic [CTR_W-1:0]                    w_cnt [NUM_CTR];
  ctr_cfg_t                            w_cfg [NUM_CTR];
  logic [NUM_CTR-1:0]                  w_en_vec;
  logic                                r_ovf_any;

  // Flush kills every lane captured this cycle.
  assign w_qual = ev_valid & ~{NUM_LANES{flush}};

  always_comb begin
    w_evt                  = '0;
    w_evt[EVT_BR]          = w_qual & ev_is_branch;
    w_evt[EVT_BR_TAKEN]    = w_qual & ev_is_branch_t;
    w_evt[EVT_BR_NT]       = w_qual & ev_is_branch & ~ev_is_branch_t;
    w_evt[EVT_COND_MISP]   = w_qual & ev_misp;
    w_evt[EVT_TGT_MISP]    = w_qual & ev_tgt_misp;
    w_evt[EVT_JAL]         = w_qual & ev_jal;
    w_evt[EVT_FLUSH_UPPER] = w_qual & ev_flush_upper;
  end

  // E1: a frozen cycle captures nothing, so held events are never counted twice.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_evt <= '0;
    end else begin
      r_evt <= freeze ? '0 : w_evt;
    end
  end

  // E2: one slice per counter. Out-of-range addresses decode to no slice.
  for (genvar k = 0; k < NUM_CTR; k++) begin : g_ctr
    logic w_hit;
    assign w_hit = wr_en && (wr_addr == AW'(k));

    exu_br_ctr_slice #(
      .NUM_LANES (NUM_LANES),
      .CTR_W     (CTR_W)
    ) u_slice (
      .clk     (clk),
      .rst_l   (rst_l),
      .freeze  (freeze),
      .evt_vec (r_evt),
      .wr_cnt  (w_hit && !wr_cfg),
      .wr_cfg  (w_hit && wr_cfg),
      .wr_data (wr_data),
      .cnt     (w_cnt[k]),
      .cfg     (w_cfg[k]),
      .ovf     (ovf[k])
    );

    assign w_en_vec[k] = w_cfg[k].en;
  end

  // The read mux shows pre-edge state. A write on the same edge is not forwarded.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CTR; k++) begin
      if (rd_addr == AW'(k)) begin
        rd_data = rd_cfg ? CTR_W'(w_cfg[k]) : w_cnt[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ovf_any <= 1'b0;
    end else begin
      r_ovf_any <= |(ovf & w_en_vec);
    end
  end

  assign ovf_any = r_ovf_any;

endmodule
`default_nettype wire

// File: tb/tb_exu_br_event_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exu_br_event_ctr
//  Description : Directed testbench for exu_br_event_ctr. It uses 2 lanes,
//                3 counters (so address 3 is out of range) and 8-bit counts.
//                A behavioural event/count model is checked on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exu_br_event_ctr;

  localparam int NL = 2;
  localparam int NC = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          freeze = 1'b0, flush = 1'b0;
  logic [NL-1:0] ev_valid = '0, ev_is_branch = '0, ev_is_branch_t = '0, ev_misp = '0;
  logic [NL-1:0] ev_tgt_misp = '0, ev_jal = '0, ev_flush_upper = '0;
  logic          wr_en = 1'b0, wr_cfg = 1'b0, rd_cfg = 1'b0;
  logic [1:0]    wr_addr = '0, rd_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [CW-1:0] rd_data;
  logic [NC-1:0] ovf;
  logic          ovf_any;

  exu_br_event_ctr #(.NUM_LANES(NL), .NUM_CTR(NC), .CTR_W(CW)) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush),
    .ev_valid(ev_valid), .ev_is_branch(ev_is_branch), .ev_is_branch_t(ev_is_branch_t),
    .ev_misp(ev_misp), .ev_tgt_misp(ev_tgt_misp), .ev_jal(ev_jal),
    .ev_flush_upper(ev_flush_upper),
    .wr_en(wr_en), .wr_cfg(wr_cfg), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_cfg(rd_cfg), .rd_data(rd_data),
    .ovf(ovf), .ovf_any(ovf_any)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Model state: counts, configs, flags, and event totals per selector
  // that are waiting to be added on the next edge.
  int         m_cnt [NC];
  logic [4:0] m_cfg [NC];
  bit         m_ovf [NC];
  bit         m_any;
  int         m_pend [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = 0; m_cfg[k] = '0; m_ovf[k] = 1'b0;
    end
    for (int e = 0; e < 8; e++) m_pend[e] = 0;
    m_any = 1'b0;
  endtask

  // Advance one clock. Next state comes from the present inputs and the model,
  // then one-shot inputs are cleared.
  task automatic tick();
    int         nc [NC];
    logic [4:0] ncf [NC];
    bit         nov [NC];
    int         np [8];
    bit         nany;
    int         inc, sum;
    for (int e = 0; e < 8; e++) np[e] = 0;
    if (!freeze && !flush) begin
      for (int l = 0; l < NL; l++) begin
        if (ev_valid[l]) begin
          if (ev_is_branch[l])                      np[1]++;
          if (ev_is_branch_t[l])                    np[2]++;
          if (ev_is_branch[l] && !ev_is_branch_t[l]) np[3]++;
          if (ev_misp[l])                           np[4]++;
          if (ev_tgt_misp[l])                       np[5]++;
          if (ev_jal[l])                            np[6]++;
          if (ev_flush_upper[l])                    np[7]++;
        end
      end
    end
    nany = 1'b0;
    for (int k = 0; k < NC; k++) begin
      nany = nany | (m_ovf[k] & m_cfg[k][4]);
      nc[k] = m_cnt[k]; ncf[k] = m_cfg[k]; nov[k] = m_ovf[k];
      if (wr_en && (int'(wr_addr) == k)) begin
        if (wr_cfg) begin
          ncf[k] = wr_data[4:0]; nov[k] = 1'b0;
        end else begin
          nc[k] = int'(wr_data);
        end
      end else begin
        inc = (m_cfg[k][4] && !freeze) ? m_pend[m_cfg[k][2:0]] : 0;
        sum = m_cnt[k] + inc;
        if (sum > 255) begin
          nov[k] = 1'b1;
          nc[k]  = m_cfg[k][3] ? 255 : sum - 256;
        end else begin
          nc[k] = sum;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = nc[k]; m_cfg[k] = ncf[k]; m_ovf[k] = nov[k];
    end
    for (int e = 0; e < 8; e++) m_pend[e] = np[e];
    m_any = nany;
    #3;
    wr_en = 1'b0; wr_cfg = 1'b0; freeze = 1'b0; flush = 1'b0;
    ev_valid = '0; ev_is_branch = '0; ev_is_branch_t = '0; ev_misp = '0;
    ev_tgt_misp = '0; ev_jal = '0; ev_flush_upper = '0;
  endtask

  task automatic wr(input bit cfg, input int addr, input int data);
    wr_en = 1'b1; wr_cfg = cfg; wr_addr = 2'(addr); wr_data = 8'(data);
    tick();
  endtask

  task automatic set_ev(input logic [1:0] v, input logic [1:0] br, input logic [1:0] bt,
                        input logic [1:0] mp, input logic [1:0] jl);
    ev_valid = v; ev_is_branch = br; ev_is_branch_t = bt; ev_misp = mp; ev_jal = jl;
  endtask

  function automatic logic [NC-1:0] m_ovf_vec();
    logic [NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k] = m_ovf[k];
    return v;
  endfunction

  // Compare process: every cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    logic [CW-1:0] exp;
    #1;
    if (checking) begin
      if (rd_addr < 2'(NC)) exp = rd_cfg ? CW'(m_cfg[rd_addr]) : CW'(m_cnt[rd_addr]);
      else                  exp = '0;
      chk("model rd_data", 32'(rd_data), 32'(exp));
      chk("model ovf", 32'(ovf), 32'(m_ovf_vec()));
      chk("model ovf_any", 32'(ovf_any), 32'(m_any));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    checking = 1'b1;
    // After reset, every count and config reads 0.
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      rd_cfg = 1'b0; #1 chk("reset cnt", 32'(rd_data), 32'h0);
      rd_cfg = 1'b1; #1 chk("reset cfg", 32'(rd_data), 32'h0);
    end
    chk("reset ovf", 32'(ovf), 32'h0);
    chk("reset ovf_any", 32'(ovf_any), 32'h0);
    rd_cfg = 1'b0; rd_addr = 2'd0;
    tick();

    // ctr0: en, wrap, BR. Two branches per cycle for three cycles.
    wr(1'b1, 0, 5'h11);
    rd_cfg = 1'b1; #1 chk("ctr0 cfg", 32'(rd_data), 32'h11);
    rd_cfg = 1'b0;
    repeat (3) begin set_ev(2'b11, 2'b11, 2'b00, 2'b00, 2'b00); tick(); end
    tick();
    chk("ctr0 br x6", 32'(rd_data), 32'd6);
    tick();
    chk("ctr0 br hold", 32'(rd_data), 32'd6);

    // ctr1: en, sat, COND_MISP. Preload 0xFE, then two mispredicts in one cycle.
    wr(1'b1, 1, 5'h1C);
    wr(1'b0, 1, 8'hFE);
    rd_addr = 2'd1;
    set_ev(2'b11, 2'b00, 2'b00, 2'b11, 2'b00); tick();
    tick();
    chk("ctr1 sat", 32'(rd_data), 32'hFF);
    chk("ctr1 ovf", 32'(ovf), 32'b010);
    chk("ovf_any lag", 32'(ovf_any), 32'd0);
    tick();
    chk("ovf_any set", 32'(ovf_any), 32'd1);
    set_ev(2'b11, 2'b00, 2'b00, 2'b11, 2'b00); tick();
    tick();
    chk("ctr1 stays FF", 32'(rd_data), 32'hFF);

    // ctr2: en, wrap, JAL. Preload all-ones; one jal wraps it to 0.
    wr(1'b1, 2, 5'h16);
    wr(1'b0, 2, 8'hFF);
    rd_addr = 2'd2;
    set_ev(2'b01, 2'b00, 2'b00, 2'b00, 2'b01); tick();
    tick();
    chk("ctr2 wrap", 32'(rd_data), 32'h0);
    chk("ctr2 ovf", 32'(ovf), 32'b110);
    wr(1'b1, 2, 5'h16);
    chk("ctr2 cfg clr ovf", 32'(ovf), 32'b010);

    // ctr0 moves to BR_TAKEN. A flushed or frozen capture must not count.
    wr(1'b1, 0, 5'h12);
    rd_addr = 2'd0;
    set_ev(2'b11, 2'b11, 2'b11, 2'b00, 2'b00); flush = 1'b1; tick();
    tick();
    chk("flush kills", 32'(rd_data), 32'd6);
    set_ev(2'b11, 2'b11, 2'b11, 2'b00, 2'b00); freeze = 1'b1; tick();
    tick();
    chk("freeze E1", 32'(rd_data), 32'd6);
    set_ev(2'b11, 2'b11, 2'b11, 2'b00, 2'b00); tick();
    freeze = 1'b1; tick();
    tick();
    chk("freeze E2", 32'(rd_data), 32'd6);
    set_ev(2'b11, 2'b11, 2'b11, 2'b00, 2'b00); tick();
    tick();
    chk("taken x2", 32'(rd_data), 32'd8);

    // A count write wins over a same-edge increment.
    set_ev(2'b11, 2'b11, 2'b11, 2'b00, 2'b00); tick();
    wr(1'b0, 0, 5);
    chk("write wins", 32'(rd_data), 32'd5);
    tick();
    chk("write wins hold", 32'(rd_data), 32'd5);

    // Address 3 is out of range: a write there is ignored and it reads 0.
    wr(1'b0, 3, 8'hAA);
    rd_addr = 2'd3; #1 chk("oor cnt", 32'(rd_data), 32'h0);
    rd_cfg = 1'b1;  #1 chk("oor cfg", 32'(rd_data), 32'h0);
    rd_cfg = 1'b0; rd_addr = 2'd1;
    tick();

    // Asynchronous reset in mid-cycle while events are pending.
    set_ev(2'b11, 2'b11, 2'b11, 2'b11, 2'b11);
    checking = 1'b0;
    #2 rst_l = 1'b0;
    #1 chk("async rst cnt", 32'(rd_data), 32'h0);
    chk("async rst ovf", 32'(ovf), 32'h0);
    chk("async rst ovf_any", 32'(ovf_any), 32'h0);
    rd_cfg = 1'b1; #1 chk("async rst cfg", 32'(rd_data), 32'h0);
    rd_cfg = 1'b0;
    model_reset();
    set_ev(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst_l = 1'b1;
    checking = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
